// File: rtl/csa_pkg.sv
// Shared definitions for the pipelined conditional-sum adder.
//   cand_t    : per-bit candidate record. sum0/c0 are the sum bit and the carry
//               out of this bit assuming the enclosing block's carry-in is 0;
//               sum1/c1 are the same assuming carry-in 1. The carry fields of
//               a block's top bit are the block carry-out candidates.
//   clog2     : ceiling log2 usable in constant expressions.
//   width_ok  : legality test for the adder width (power of two, 4..64).
package csa_pkg;

  typedef struct packed {
    logic sum0;
    logic c0;
    logic sum1;
    logic c1;
  } cand_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic bit width_ok(input int w);
    return (w >= 4) && (w <= 64) && ((w & (w - 1)) == 0);
  endfunction

endpackage

// File: rtl/csa_merge_level.sv
// One registered merge level of the conditional-sum tree.
// Pairs adjacent BLK-bit candidate blocks into 2*BLK-bit blocks: the upper half
// of each pair takes, for each carry-in assumption, the candidate selected by
// the lower half's carry-out under that same assumption; the lower half passes
// through. Carry-in select, operand sign bits and the valid bit travel along.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   adv               pipeline advance enable
//   src_vld/ce/xm/ym  valid, effective carry-in, X MSB, effective Y MSB in
//   src_cand          BLK*NBLK candidate records in
//   vld/ce/xm/ym      registered sidebands out
//   cand              registered merged candidate records out
module csa_merge_level
  import csa_pkg::*;
#(
  parameter int BLK  = 1,
  parameter int NBLK = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   adv,
  input  logic                   src_vld,
  input  logic                   src_ce,
  input  logic                   src_xm,
  input  logic                   src_ym,
  input  cand_t [BLK*NBLK-1:0]   src_cand,
  output logic                   vld,
  output logic                   ce,
  output logic                   xm,
  output logic                   ym,
  output cand_t [BLK*NBLK-1:0]   cand
);

  localparam int W = BLK * NBLK;

  cand_t [W-1:0] merged;

  for (genvar j = 0; j < W; j++) begin : g_bit
    if ((j % (2 * BLK)) >= BLK) begin : g_upper
      // Top bit of the lower half of this pair holds that half's carry-out.
      localparam int LOW_TOP = (j / (2 * BLK)) * (2 * BLK) + BLK - 1;
      assign merged[j] = '{
        sum0: src_cand[LOW_TOP].c0 ? src_cand[j].sum1 : src_cand[j].sum0,
        c0:   src_cand[LOW_TOP].c0 ? src_cand[j].c1   : src_cand[j].c0,
        sum1: src_cand[LOW_TOP].c1 ? src_cand[j].sum1 : src_cand[j].sum0,
        c1:   src_cand[LOW_TOP].c1 ? src_cand[j].c1   : src_cand[j].c0
      };
    end else begin : g_lower
      assign merged[j] = src_cand[j];
    end
  end

  // Stage boundary: merged blocks of 2*BLK bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld  <= 1'b0;
      ce   <= 1'b0;
      xm   <= 1'b0;
      ym   <= 1'b0;
      cand <= '0;
    end else if (adv) begin
      vld  <= src_vld;
      ce   <= src_ce;
      xm   <= src_xm;
      ym   <= src_ym;
      cand <= merged;
    end
  end

endmodule

// File: rtl/cond_sum_adder_pipe.sv
// Pipelined conditional-sum adder/subtractor with valid/ready handshake.
// S0 registers per-bit candidates, LOG2W-1 merge levels double the block size,
// and the final stage merges the two halves, selects the candidate matching the
// effective carry-in and registers sum, carry-out and signed overflow.
// Latency LOG2W+1 cycles, one operation per cycle, stall-all back-pressure.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid, in_ready         operand handshake
//   in_x, in_y, in_cin, in_sub operands, carry-in (add only), 1 = X - Y
//   out_valid, out_ready       result handshake
//   out_sum, out_cout, out_ovf result, carry-out (1 = no borrow), overflow
module cond_sum_adder_pipe
  import csa_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int LOG2W = clog2(WIDTH);
  localparam int LAST  = LOG2W - 1;
  localparam int HALF  = WIDTH / 2;

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("cond_sum_adder_pipe: WIDTH must be a power of two in 4..64");
  end

  logic adv;

  // The whole pipe moves together; it only stops when a result is waiting.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic [WIDTH-1:0]  ye;
  logic              ce;
  cand_t [WIDTH-1:0] cand_s0;

  assign ye = in_sub ? ~in_y : in_y;
  assign ce = in_sub | in_cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_s0
    assign cand_s0[i] = '{
      sum0: in_x[i] ^ ye[i],
      c0:   in_x[i] & ye[i],
      sum1: ~(in_x[i] ^ ye[i]),
      c1:   in_x[i] | ye[i]
    };
  end

  logic              vld_p0, ce_p0, xm_p0, ym_p0;
  cand_t [WIDTH-1:0] cand_p0;

  // Stage boundary S0: single-bit candidates; operands only captured when valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      ce_p0   <= 1'b0;
      xm_p0   <= 1'b0;
      ym_p0   <= 1'b0;
      cand_p0 <= '0;
    end else if (adv) begin
      vld_p0 <= in_valid;
      if (in_valid) begin
        ce_p0   <= ce;
        xm_p0   <= in_x[WIDTH-1];
        ym_p0   <= ye[WIDTH-1];
        cand_p0 <= cand_s0;
      end
    end
  end

  // Index k holds the output of merge level k (blocks of 2^k bits); 0 is S0.
  logic              vld_lvl  [LOG2W];
  logic              ce_lvl   [LOG2W];
  logic              xm_lvl   [LOG2W];
  logic              ym_lvl   [LOG2W];
  cand_t [WIDTH-1:0] cand_lvl [LOG2W];

  assign vld_lvl[0]  = vld_p0;
  assign ce_lvl[0]   = ce_p0;
  assign xm_lvl[0]   = xm_p0;
  assign ym_lvl[0]   = ym_p0;
  assign cand_lvl[0] = cand_p0;

  for (genvar k = 1; k < LOG2W; k++) begin : g_lvl
    csa_merge_level #(
      .BLK  (1 << (k - 1)),
      .NBLK (WIDTH >> (k - 1))
    ) u_merge (
      .clk      (clk),
      .rst_n    (rst_n),
      .adv      (adv),
      .src_vld  (vld_lvl[k-1]),
      .src_ce   (ce_lvl[k-1]),
      .src_xm   (xm_lvl[k-1]),
      .src_ym   (ym_lvl[k-1]),
      .src_cand (cand_lvl[k-1]),
      .vld      (vld_lvl[k]),
      .ce       (ce_lvl[k]),
      .xm       (xm_lvl[k]),
      .ym       (ym_lvl[k]),
      .cand     (cand_lvl[k])
    );
  end

  // Last merge and carry-in selection fused: the lower half resolves with the
  // real carry-in, and its resolved carry-out picks the upper half's candidate.
  logic             hc;
  logic [WIDTH-1:0] sum_fin;
  logic             cout_fin;

  assign hc = ce_lvl[LAST] ? cand_lvl[LAST][HALF-1].c1 : cand_lvl[LAST][HALF-1].c0;

  for (genvar j = 0; j < WIDTH; j++) begin : g_fin
    if (j < HALF) begin : g_lo
      assign sum_fin[j] = ce_lvl[LAST] ? cand_lvl[LAST][j].sum1 : cand_lvl[LAST][j].sum0;
    end else begin : g_hi
      assign sum_fin[j] = hc ? cand_lvl[LAST][j].sum1 : cand_lvl[LAST][j].sum0;
    end
  end

  assign cout_fin = hc ? cand_lvl[LAST][WIDTH-1].c1 : cand_lvl[LAST][WIDTH-1].c0;

  // Stage boundary: final result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (adv) begin
      out_valid <= vld_lvl[LAST];
      out_sum   <= sum_fin;
      out_cout  <= cout_fin;
      out_ovf   <= (xm_lvl[LAST] == ym_lvl[LAST]) && (sum_fin[WIDTH-1] != xm_lvl[LAST]);
    end
  end

endmodule

// File: tb/tb_cond_sum_adder_pipe.sv
// Scoreboard bench: three independent lanes (WIDTH 8, 16, 32) share one clock.
// Each lane drives operands, pushes the arithmetic expectation into a queue at
// issue time, and a monitor pops and compares whenever a result is consumed.
module tb_cond_sum_adder_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input int w, input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL w%0d_%s: got 0x%0h, expected 0x%0h at %0t", w, name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int W      = 8 << g;
    localparam int LAT    = $clog2(W) + 1;
    localparam int N_RAND = 10000;

    logic         rst_n     = 1'b1;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_x      = '0;
    logic [W-1:0] in_y      = '0;
    logic         in_cin    = 1'b0;
    logic         in_sub    = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;

    logic [W+1:0] sb [$];   // {ovf, cout, sum}
    int           rdy_mode = 0;
    bit           done     = 1'b0;

    cond_sum_adder_pipe #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x      (in_x),
      .in_y      (in_y),
      .in_cin    (in_cin),
      .in_sub    (in_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf)
    );

    // Plain integer arithmetic: unsigned result for sum/carry, signed range for overflow.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic cin, input logic sub);
      longint ux, uy, sx, sy, s, r, lo, hi;
      logic [W-1:0] res;
      logic co;
      ux = 64'(x);
      uy = 64'(y);
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      lo = -(longint'(1) <<< (W - 1));
      hi = (longint'(1) <<< (W - 1)) - 1;
      if (sub) begin
        s  = ux - uy;
        co = (ux >= uy);
        r  = sx - sy;
      end else begin
        s  = ux + uy + 64'(cin);
        co = ((s >>> W) != 0);
        r  = sx + sy + 64'(cin);
      end
      res = s[W-1:0];
      return {(r < lo) || (r > hi), co, res};
    endfunction

    initial begin : rdy_drv
      int cyc;
      bit [5:0] pat;
      cyc = 0;
      pat = 6'b011001;   // 1,0,0,1,1,0 from bit 0 upward
      forever begin
        @(posedge clk); #1;
        cyc++;
        case (rdy_mode)
          0:       out_ready = 1'b1;
          1:       out_ready = pat[cyc % 6];
          2:       out_ready = ($urandom_range(3) != 0);
          default: out_ready = 1'b0;
        endcase
      end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic cin, input logic sub);
      int waits;
      waits    = 0;
      in_valid = 1'b1;
      in_x     = x;
      in_y     = y;
      in_cin   = cin;
      in_sub   = sub;
      @(negedge clk);
      while (!in_ready && waits < 100) begin
        waits++;
        @(negedge clk);
      end
      if (in_ready) sb.push_back(model(x, y, cin, sub));
      else check(W, "in_ready_timeout", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
    endtask

    task automatic lat_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic cin, input logic sub);
      int n;
      issue(x, y, cin, sub);
      n = 1;
      while (!out_valid && n < 4 * LAT) begin
        @(posedge clk); #1;
        n++;
      end
      check(W, "latency", 64'(n), 64'(LAT));
      @(posedge clk); #1;
    endtask

    task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 500) begin
        @(posedge clk); #1;
        n++;
      end
      check(W, "drain_left", 64'(sb.size()), 64'd0);
    endtask

    initial begin : mon
      logic [W+1:0] exp_r;
      logic [W+1:0] held;
      bit           stall;
      stall = 1'b0;
      held  = '0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          stall = 1'b0;
          continue;
        end
        check(W, "in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
        if (stall) begin
          check(W, "hold_valid", 64'(out_valid), 64'd1);
          check(W, "hold_data", 64'({out_ovf, out_cout, out_sum}), 64'(held));
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check(W, "spurious_result", 64'(out_valid), 64'd0);
          end else begin
            exp_r = sb.pop_front();
            check(W, "sum",  64'(out_sum),  64'(exp_r[W-1:0]));
            check(W, "cout", 64'(out_cout), 64'(exp_r[W]));
            check(W, "ovf",  64'(out_ovf),  64'(exp_r[W+1]));
          end
        end
        stall = out_valid && !out_ready;
        held  = {out_ovf, out_cout, out_sum};
      end
    end

    initial begin : main
      logic [W-1:0] ones, maxpos, minneg;
      int n;
      ones   = '1;
      maxpos = ones >> 1;
      minneg = ~maxpos;

      #1 rst_n = 1'b0;
      #1;
      check(W, "rst_valid", 64'(out_valid), 64'd0);
      check(W, "rst_sum",   64'(out_sum),   64'd0);
      check(W, "rst_cout",  64'(out_cout),  64'd0);
      check(W, "rst_ovf",   64'(out_ovf),   64'd0);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;
      check(W, "ready_after_rst", 64'(in_ready), 64'd1);

      // Boundary vectors, one at a time on an empty pipe
      rdy_mode = 0;
      lat_op(maxpos, W'(1), 1'b0, 1'b0);
      lat_op(ones,   W'(1), 1'b0, 1'b0);
      lat_op(W'(0),  W'(0), 1'b1, 1'b0);
      lat_op(W'(5),  W'(7), 1'b0, 1'b1);
      lat_op(minneg, W'(1), 1'b0, 1'b1);
      lat_op(minneg, W'(1), 1'b1, 1'b1);
      lat_op(ones,   W'(0), 1'b1, 1'b0);

      // Back-to-back operations against the 1,0,0,1,1,0 consumer pattern
      rdy_mode = 1;
      for (int i = 0; i < 32; i++)
        issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      rdy_mode = 0;
      drain();

      // Reset while three operations are in flight and one is stalled at the output
      rdy_mode = 3;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++)
        issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      n = 0;
      while (!out_valid && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      check(W, "rst_setup_valid", 64'(out_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check(W, "midrst_valid", 64'(out_valid), 64'd0);
      check(W, "midrst_sum",   64'(out_sum),   64'd0);
      check(W, "midrst_cout",  64'(out_cout),  64'd0);
      check(W, "midrst_ovf",   64'(out_ovf),   64'd0);
      sb.delete();
      rdy_mode = 0;
      @(posedge clk); #3 rst_n = 1'b1;
      @(posedge clk); #1;
      check(W, "ready_after_midrst", 64'(in_ready), 64'd1);
      lat_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));

      // Random traffic with random bubbles and random consumer stalls
      rdy_mode = 2;
      for (int i = 0; i < N_RAND; i++) begin
        issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        in_x = W'($urandom);
        in_y = W'($urandom);
        if ($urandom_range(3) == 0) begin
          @(posedge clk); #1;
        end
      end
      rdy_mode = 0;
      drain();
      done = 1'b1;
    end
  end

  initial begin : finish_ctl
    int n;
    n = 0;
    while (!(lane[0].done && lane[1].done && lane[2].done) && n < 90000) begin
      @(posedge clk);
      n++;
    end
    check(0, "all_lanes_done", 64'(lane[0].done && lane[1].done && lane[2].done), 64'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
